// File: rtl/ex_mdu_seq_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer.
// Holds the opcode/funct codes that identify M-extension instructions,
// the sequencer state type and the iteration-step mode type.
package ex_mdu_seq_pkg;

    localparam logic [6:0] OP_R       = 7'b0110011;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    localparam logic [2:0] F3_MUL     = 3'b000;
    localparam logic [2:0] F3_MULH    = 3'b001;
    localparam logic [2:0] F3_MULHSU  = 3'b010;
    localparam logic [2:0] F3_MULHU   = 3'b011;
    localparam logic [2:0] F3_DIV     = 3'b100;
    localparam logic [2:0] F3_DIVU    = 3'b101;
    localparam logic [2:0] F3_REM     = 3'b110;
    localparam logic [2:0] F3_REMU    = 3'b111;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_CALC = 2'd1,
        MDU_FIX  = 2'd2,
        MDU_DONE = 2'd3
    } mdu_state_t;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } mdu_mode_t;

endpackage

// File: rtl/ex_mdu_seq_iter_step.sv
// One iteration of the unsigned multiply/divide datapath (combinational).
//   acc      : working register. MUL: {partial product, multiplier};
//              DIV: {remainder, dividend/quotient}
//   operand  : multiplicand (MUL) or divisor (DIV) magnitude
//   mode     : MODE_MUL shift-add (LSB first), MODE_DIV restoring divide
//   acc_next : working register after this iteration
module mdu_iter_step
    import ex_mdu_seq_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   operand,
    input  mdu_mode_t         mode,
    output logic [2*XLEN-1:0] acc_next
);

    logic [XLEN:0] mul_sum;
    logic [XLEN:0] div_shift;
    logic [XLEN:0] div_diff;

    always_comb begin
        // Add the multiplicand into the upper half when the current
        // multiplier bit is set; the carry is kept and shifted in.
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]};
        if (acc[0]) begin
            mul_sum = mul_sum + {1'b0, operand};
        end

        // Remainder shifted left by one with the next dividend bit; it can
        // transiently need XLEN+1 bits, hence the extra bit.
        div_shift = acc[2*XLEN-1:XLEN-1];
        div_diff  = div_shift - {1'b0, operand};

        if (mode == MODE_MUL) begin
            acc_next = {mul_sum, acc[XLEN-1:1]};
        end else if (!div_diff[XLEN]) begin
            acc_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end else begin
            acc_next = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/ex_mdu_seq.sv
// RV32M multi-cycle multiply/divide sequencer for the EX stage.
// Runs a 32-iteration unsigned datapath on operand magnitudes, fixes the
// sign afterwards and presents a one-cycle registered writeback.
//   clk, rst            : clock, asynchronous active-high reset
//   start_i             : M-extension instruction present in EX (level)
//   funct3_i            : MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU
//   rs1_data_i/rs2_data_i : operands A and B
//   rd_addr_i           : destination register, latched on accept
//   flush_i             : abort any operation, no writeback
//   stall_o             : combinational hold request to IF/ID/EX
//   done_o / rd_we      : result valid for one cycle
//   rd_addr / rd_data   : registered destination and result
module ex_mdu_seq
    import ex_mdu_seq_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            done_o,
    output logic            rd_we,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] rd_data
);

    localparam logic [XLEN-1:0] SIGNED_MIN = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_t        state, state_next;
    logic [5:0]        cnt;
    logic [2:0]        funct3_q;
    logic [4:0]        rd_addr_q;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] acc_next;
    logic [XLEN-1:0]   op_b;
    logic              neg_res;
    logic              neg_rem;
    mdu_mode_t         mode;

    // Accept-side decode
    logic              accept;
    logic              is_div;
    logic              a_signed, b_signed;
    logic              a_neg, b_neg;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic              div_zero, div_ovf, special;
    logic [XLEN-1:0]   special_val;

    // Sign fix
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_result;

    always_comb begin
        accept   = (state == MDU_IDLE) && start_i && !flush_i;
        is_div   = funct3_i[2];
        a_signed = (funct3_i == F3_MULH) || (funct3_i == F3_MULHSU) ||
                   (is_div && !funct3_i[0]);
        b_signed = (funct3_i == F3_MULH) || (is_div && !funct3_i[0]);
        a_neg    = a_signed && rs1_data_i[XLEN-1];
        b_neg    = b_signed && rs2_data_i[XLEN-1];
        abs_a    = a_neg ? -rs1_data_i : rs1_data_i;
        abs_b    = b_neg ? -rs2_data_i : rs2_data_i;

        div_zero = is_div && (rs2_data_i == '0);
        div_ovf  = is_div && !funct3_i[0] &&
                   (rs1_data_i == SIGNED_MIN) && (rs2_data_i == '1);
        special  = div_zero || div_ovf;

        // funct3[1] distinguishes REM* from DIV*
        if (div_zero) begin
            special_val = funct3_i[1] ? rs1_data_i : '1;
        end else begin
            special_val = funct3_i[1] ? '0 : SIGNED_MIN;
        end
    end

    assign mode = funct3_q[2] ? MODE_DIV : MODE_MUL;

    mdu_iter_step #(
        .XLEN(XLEN)
    ) u_step (
        .acc      (acc),
        .operand  (op_b),
        .mode     (mode),
        .acc_next (acc_next)
    );

    always_comb begin
        prod_fix = neg_res ? -acc : acc;
        quo_fix  = neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem_fix  = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        case (funct3_q)
            F3_MUL:                  fix_result = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU,
            F3_MULHU:                fix_result = prod_fix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:         fix_result = quo_fix;
            default:                 fix_result = rem_fix;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            MDU_IDLE: if (accept) state_next = special ? MDU_DONE : MDU_CALC;
            MDU_CALC: if (cnt == 6'd31) state_next = MDU_FIX;
            MDU_FIX:  state_next = MDU_DONE;
            MDU_DONE: state_next = MDU_IDLE;
            default:  state_next = MDU_IDLE;
        endcase
        if (flush_i) begin
            state_next = MDU_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= MDU_IDLE;
            cnt       <= '0;
            funct3_q  <= '0;
            rd_addr_q <= '0;
            acc       <= '0;
            op_b      <= '0;
            neg_res   <= 1'b0;
            neg_rem   <= 1'b0;
            rd_addr   <= '0;
            rd_data   <= '0;
        end else begin
            state <= state_next;
            case (state)
                MDU_IDLE: begin
                    if (accept) begin
                        // Multiply and divide share the same initial layout:
                        // {zeros, |A|} with |B| as the iteration operand.
                        funct3_q  <= funct3_i;
                        rd_addr_q <= rd_addr_i;
                        acc       <= {{XLEN{1'b0}}, abs_a};
                        op_b      <= abs_b;
                        neg_res   <= a_neg ^ b_neg;
                        neg_rem   <= a_neg;
                        cnt       <= '0;
                        if (special) begin
                            rd_data <= special_val;
                            rd_addr <= rd_addr_i;
                        end
                    end
                end
                MDU_CALC: begin
                    acc <= acc_next;
                    cnt <= cnt + 6'd1;
                end
                MDU_FIX: begin
                    if (!flush_i) begin
                        rd_data <= fix_result;
                        rd_addr <= rd_addr_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign done_o  = (state == MDU_DONE);
    assign rd_we   = done_o;
    assign stall_o = accept || (state == MDU_CALC) || (state == MDU_FIX);

endmodule

// File: tb/tb_ex_mdu_seq.sv
module tb_ex_mdu_seq;
    import ex_mdu_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic [2:0]  funct3_i = '0;
    logic [31:0] rs1_data_i = '0;
    logic [31:0] rs2_data_i = '0;
    logic [4:0]  rd_addr_i = '0;
    logic        flush_i = 1'b0;
    logic        stall_o, done_o, rd_we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;

    ex_mdu_seq #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .funct3_i   (funct3_i),
        .rs1_data_i (rs1_data_i),
        .rs2_data_i (rs2_data_i),
        .rd_addr_i  (rd_addr_i),
        .flush_i    (flush_i),
        .stall_o    (stall_o),
        .done_o     (done_o),
        .rd_we      (rd_we),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every writeback must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done_o) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got rd_data %h rd_addr %0d with nothing expected", rd_data, rd_addr);
            end else begin
                e = exp_q.pop_front();
                check({e.name, "_data"}, rd_data, e.data);
                check({e.name, "_addr"}, {27'b0, rd_addr}, {27'b0, e.addr});
                check({e.name, "_we"}, {31'b0, rd_we}, 32'd1);
            end
        end
    end

    task automatic push_exp(input logic [4:0] rd, input logic [31:0] data, input string name);
        exp_t e;
        e.addr = rd;
        e.data = data;
        e.name = name;
        exp_q.push_back(e);
    endtask

    // Issue one op, then measure done latency and stall cycles.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp, input int exp_lat,
                          input string name);
        int lat;
        int stalls;
        @(negedge clk);
        start_i = 1'b1; funct3_i = f3; rs1_data_i = a; rs2_data_i = b; rd_addr_i = rd;
        push_exp(rd, exp, name);
        #1;
        stalls = stall_o ? 1 : 0;
        @(posedge clk);
        #1 start_i = 1'b0;
        lat = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (stall_o) stalls++;
            if (done_o) begin
                lat = k;
                break;
            end
        end
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_stall_cycles"}, stalls, (exp_lat == 34) ? 34 : 1);
    endtask

    initial begin
        int t1, t2, cyc;

        // Reset state
        #12;
        check("reset_stall", {31'b0, stall_o}, 32'd0);
        check("reset_done", {31'b0, done_o}, 32'd0);
        check("reset_rd_we", {31'b0, rd_we}, 32'd0);
        check("reset_rd_addr", {27'b0, rd_addr}, 32'd0);
        check("reset_rd_data", rd_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(F3_MUL,    32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 34, "mul_7_m3");
        run_op(F3_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd6,  32'h0000_0000, 34, "mulh_m1_m1");
        run_op(F3_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFF, 34, "mulhsu_m1_max");
        run_op(F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFE, 34, "mulhu_max_max");
        run_op(F3_DIV,    32'hFFFF_FFF9,  32'd2,         5'd10, 32'hFFFF_FFFD, 34, "div_m7_2");
        run_op(F3_REM,    32'hFFFF_FFF9,  32'd2,         5'd11, 32'hFFFF_FFFF, 34, "rem_m7_2");
        run_op(F3_DIVU,   32'd100,        32'd7,         5'd12, 32'd14,        34, "divu_100_7");
        run_op(F3_REMU,   32'd100,        32'd7,         5'd13, 32'd2,         34, "remu_100_7");
        run_op(F3_DIVU,   32'd5,          32'd0,         5'd14, 32'hFFFF_FFFF, 1,  "divu_by_zero");
        run_op(F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd15, 32'd0,         1,  "rem_ovf");
        run_op(F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 1,  "div_ovf");
        run_op(F3_REM,    32'd5,          32'd0,         5'd17, 32'd5,         1,  "rem_by_zero");

        // Result holds after DONE
        repeat (5) @(negedge clk);
        check("hold_rd_data", rd_data, 32'd5);
        check("hold_rd_addr", {27'b0, rd_addr}, 32'd17);

        // start and flush together in IDLE: no accept
        @(negedge clk);
        start_i = 1'b1; flush_i = 1'b1; funct3_i = F3_MUL; rs1_data_i = 32'd2; rs2_data_i = 32'd2; rd_addr_i = 5'd1;
        #1 check("start_flush_stall", {31'b0, stall_o}, 32'd0);
        @(posedge clk);
        #1 start_i = 1'b0; flush_i = 1'b0;
        repeat (40) @(negedge clk);

        // Flush at cnt = 10 (cycle E+11)
        @(negedge clk);
        start_i = 1'b1; funct3_i = F3_MUL; rs1_data_i = 32'd9; rs2_data_i = 32'd9; rd_addr_i = 5'd2;
        @(posedge clk);
        #1 start_i = 1'b0;
        repeat (11) @(negedge clk);
        flush_i = 1'b1;
        @(posedge clk);
        #1 flush_i = 1'b0;
        @(negedge clk);
        check("flush_stall", {31'b0, stall_o}, 32'd0);
        check("flush_done", {31'b0, done_o}, 32'd0);
        repeat (40) @(negedge clk);
        run_op(F3_MUL, 32'd3, 32'd4, 5'd9, 32'd12, 34, "mul_after_flush");

        // Reset mid-CALC
        @(negedge clk);
        start_i = 1'b1; funct3_i = F3_MUL; rs1_data_i = 32'd5; rs2_data_i = 32'd5; rd_addr_i = 5'd3;
        @(posedge clk);
        #1 start_i = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_stall", {31'b0, stall_o}, 32'd0);
        check("midrst_done", {31'b0, done_o}, 32'd0);
        check("midrst_rd_we", {31'b0, rd_we}, 32'd0);
        check("midrst_rd_addr", {27'b0, rd_addr}, 32'd0);
        check("midrst_rd_data", rd_data, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Back-to-back with start held through DONE
        @(negedge clk);
        start_i = 1'b1; funct3_i = F3_MUL; rs1_data_i = 32'd6; rs2_data_i = 32'd7; rd_addr_i = 5'd4;
        push_exp(5'd4, 32'd42, "b2b_first");
        push_exp(5'd4, 32'd42, "b2b_second");
        t1 = -1; t2 = -1; cyc = 0;
        while (cyc < 200 && t2 < 0) begin
            @(negedge clk);
            cyc++;
            if (done_o) begin
                if (t1 < 0) t1 = cyc;
                else begin
                    t2 = cyc;
                    start_i = 1'b0;
                end
            end
        end
        start_i = 1'b0;
        check("b2b_both_seen", {31'b0, (t1 >= 0 && t2 >= 0)}, 32'd1);
        check("b2b_spacing", t2 - t1, 32'd35);

        repeat (40) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
